// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM pipeline stage: FSM state encoding,
// default widths and the instruction-word value used for MEM/WB bubbles.
package mem_stage_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RADDR_W = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // A zero instruction word marks a bubble in the writeback trace.
  localparam logic [31:0] ISE_BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus. The pipeline stage is the master; the
// memory (or a bench model) is the slave.
interface mem_access_stage_if #(
  parameter int DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);

endinterface

// File: rtl/mem_access_stage_wait_timer.sv
// Saturating counter of unacknowledged BUSY cycles; at_max flags the
// cycle in which an outstanding access must be aborted.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic at_max
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign at_max = (wait_cnt == CNT_W'(MAX_WAIT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wait_cnt <= '0;
    end else if (en && !at_max) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues the EX/MEM load/store on the dmem bus, stalls
// upstream while it is outstanding and loads MEM/WB. Option: MISALIGN_CHECK_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RADDR_W  = DEF_RADDR_W,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Reg_w_in,
  input  logic               Mem_to_reg_in,
  input  logic               Mem_w_in,
  input  logic [DATA_W-1:0]  ALU_Result_in,
  input  logic [DATA_W-1:0]  RtData_in,
  input  logic [RADDR_W-1:0] RdAddr_in,
  input  logic [31:0]        ISE_in,
  mem_access_stage_if.master dmem,
  output logic               stall_out,
  output logic               Reg_w_out,
  output logic               Mem_to_reg_out,
  output logic [DATA_W-1:0]  ALU_Result_out,
  output logic [RADDR_W-1:0] RdAddr_out,
  output logic [31:0]        ISE_out,
  output logic [DATA_W-1:0]  Mem_data_out,
  output logic               err_out
);

  state_t state;
  logic   mem_op, is_load, misalign, busy, at_max, abort, issue;

  assign mem_op  = Mem_w_in | Mem_to_reg_in;
  assign is_load = Mem_to_reg_in & ~Mem_w_in;
  assign busy    = (state == ST_BUSY);

`ifdef MISALIGN_CHECK_EN
  assign misalign = mem_op & (ALU_Result_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (~busy),
    .en     (busy & ~dmem.ready),
    .at_max (at_max)
  );

  // Ready arriving in the timeout cycle still counts as a completion.
  assign abort = busy & at_max & ~dmem.ready;
  assign issue = busy | (mem_op & ~misalign);

  assign dmem.req   = issue & ~rst;
  assign dmem.we    = dmem.req & Mem_w_in;
  assign dmem.addr  = ALU_Result_in;
  assign dmem.wdata = RtData_in;

  assign stall_out = issue & ~dmem.ready & ~abort & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      Reg_w_out      <= 1'b0;
      Mem_to_reg_out <= 1'b0;
      ALU_Result_out <= '0;
      RdAddr_out     <= '0;
      ISE_out        <= ISE_BUBBLE;
      Mem_data_out   <= '0;
      err_out        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (issue && !dmem.ready) state <= ST_BUSY;
        ST_BUSY: if (dmem.ready || abort)  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // A stalled cycle must not reach writeback twice, so MEM/WB gets a bubble.
      if (stall_out) begin
        Reg_w_out      <= 1'b0;
        Mem_to_reg_out <= 1'b0;
        ALU_Result_out <= '0;
        RdAddr_out     <= '0;
        ISE_out        <= ISE_BUBBLE;
        Mem_data_out   <= '0;
      end else begin
        Reg_w_out      <= Reg_w_in & ~abort & ~misalign;
        Mem_to_reg_out <= is_load;
        ALU_Result_out <= ALU_Result_in;
        RdAddr_out     <= RdAddr_in;
        ISE_out        <= ISE_in;
        Mem_data_out   <= (is_load && issue && dmem.ready) ? dmem.rdata : '0;
      end

      if (abort || misalign) err_out <= 1'b1;
    end
  end

endmodule
